// File: rtl/midi_merge_arb_if.sv
// Bundle of the per-input FIFO heads, the shared transmit handshake and arbiter status.
// master is the arbiter side; slave is the FIFO/transmitter side.
interface midi_merge_arb_if;
    logic [3:0]  req_empty_n;
    logic [31:0] req_data_i;
    logic [3:0]  req_rd_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [1:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;

    modport master (
        input  req_empty_n, req_data_i, tx_ready_i,
        output req_rd_o, tx_data_o, tx_valid_o, grant_o, busy_o, timeout_o
    );

    modport slave (
        output req_empty_n, req_data_i, tx_ready_i,
        input  req_rd_o, tx_data_o, tx_valid_o, grant_o, busy_o, timeout_o
    );
endinterface

// File: rtl/midi_merge_arb.sv
// Message-aware round-robin merge of four MIDI receive FIFOs onto one transmit stream.
// A grant is held for a whole message (running status, SysEx) and dropped on a stall timeout.
module midi_merge_arb #(
    parameter logic [15:0] TIMEOUT = 16'd3125
) (
    input logic              wb_clk_i,
    input logic              wb_rst_i,
    midi_merge_arb_if.master bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StSend, StWait} state_e;

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rem_q, rem_d;
    logic        first_q, first_d;
    logic        single_q, single_d;
    logic        sysex_q, sysex_d;
    logic [3:0]  rs_valid_q, rs_valid_d;
    logic [1:0]  rs_len_q [4];
    logic [1:0]  rs_len_d [4];
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic [7:0]  head_byte;
    logic [15:0] cnt_inc;
    logic [3:0]  req_rd;
    logic        timeout;
    logic        found;
    logic [1:0]  scan_idx;

    assign head_byte = bus.req_data_i[{grant_q, 3'b000} +: 8];
    assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        rem_d      = rem_q;
        first_d    = first_q;
        single_d   = single_q;
        sysex_d    = sysex_q;
        rs_valid_d = rs_valid_q;
        rs_len_d   = rs_len_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        req_rd     = '0;
        timeout    = 1'b0;
        found      = 1'b0;
        scan_idx   = ptr_q;

        case (state_q)
            StIdle: begin
                for (int i = 0; i < 4; i++) begin
                    scan_idx = ptr_q + 2'(i);
                    if (!found && bus.req_empty_n[scan_idx]) begin
                        found   = 1'b1;
                        grant_d = scan_idx;
                    end
                end
                if (found) begin
                    first_d  = 1'b1;
                    single_d = 1'b0;
                    state_d  = StLoad;
                end
            end

            StLoad: begin
                req_rd[grant_q] = 1'b1;
                tx_data_d       = head_byte;
                state_d         = StSend;
                if (head_byte[7] && head_byte[7:4] != 4'hF) begin
                    // Channel voice: program change and channel pressure (Cx/Dx) carry one data byte
                    rem_d               = (head_byte[7:5] == 3'b110) ? 2'd1 : 2'd2;
                    rs_len_d[grant_q]   = rem_d;
                    rs_valid_d[grant_q] = 1'b1;
                end else if (head_byte[7]) begin
                    case (head_byte[3:0])
                        4'h0: begin
                            sysex_d             = 1'b1;
                            rs_valid_d[grant_q] = 1'b0;
                        end
                        4'h1, 4'h3: begin
                            rem_d               = 2'd1;
                            rs_valid_d[grant_q] = 1'b0;
                        end
                        4'h2: begin
                            rem_d               = 2'd2;
                            rs_valid_d[grant_q] = 1'b0;
                        end
                        4'h4, 4'h5, 4'h6, 4'h7: begin
                            rem_d               = 2'd0;
                            sysex_d             = 1'b0;
                            rs_valid_d[grant_q] = 1'b0;
                        end
                        default: begin
                            // Real-time bytes pass through without touching message state
                            if (first_q) begin
                                single_d = 1'b1;
                            end
                        end
                    endcase
                end else if (first_q) begin
                    if (rs_valid_q[grant_q]) begin
                        rem_d = rs_len_q[grant_q] - 2'd1;
                    end else begin
                        // Stray data byte: dropped after the pop
                        ptr_d   = grant_q + 2'd1;
                        state_d = StIdle;
                    end
                end else if (!sysex_q) begin
                    rem_d = rem_q - 2'd1;
                end
            end

            StSend: begin
                if (bus.tx_ready_i) begin
                    first_d = 1'b0;
                    if (single_q || (!sysex_q && rem_q == 2'd0)) begin
                        ptr_d   = grant_q + 2'd1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                if (bus.req_empty_n[grant_q]) begin
                    cnt_d   = '0;
                    state_d = StLoad;
                end else if (cnt_inc >= TIMEOUT) begin
                    timeout             = 1'b1;
                    cnt_d               = '0;
                    sysex_d             = 1'b0;
                    rs_valid_d[grant_q] = 1'b0;
                    ptr_d               = grant_q + 2'd1;
                    state_d             = StIdle;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            rem_q      <= '0;
            first_q    <= 1'b0;
            single_q   <= 1'b0;
            sysex_q    <= 1'b0;
            rs_valid_q <= '0;
            rs_len_q   <= '{default: 2'd0};
            cnt_q      <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            single_q   <= single_d;
            sysex_q    <= sysex_d;
            rs_valid_q <= rs_valid_d;
            rs_len_q   <= rs_len_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.req_rd_o   = req_rd;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.tx_valid_o = (state_q == StSend);
    assign bus.grant_o    = grant_q;
    assign bus.busy_o     = (state_q != StIdle);
    assign bus.timeout_o  = timeout;

endmodule

// File: tb/tb_midi_merge_arb.sv
// Directed bench for midi_merge_arb: FIFO models feed four ports, a monitor logs every
// accepted byte with its grant and cycle, and the main sequence checks against hand values.
module tb_midi_merge_arb;

    logic wb_clk = 1'b0;
    logic wb_rst;
    logic flush;

    always #5 wb_clk = ~wb_clk;

    midi_merge_arb_if bus ();

    midi_merge_arb #(
        .TIMEOUT (16'd8)
    ) dut (
        .wb_clk_i (wb_clk),
        .wb_rst_i (wb_rst),
        .bus      (bus)
    );

    // Per-port FIFO models
    logic [7:0]  fmem  [4][32];
    logic [7:0]  fhead [4];
    logic [7:0]  ftail [4];
    logic [3:0]  ne;
    logic [31:0] hd;

    always_comb begin
        ne = '0;
        hd = '0;
        for (int p = 0; p < 4; p++) begin
            ne[p]         = (fhead[p] != ftail[p]);
            hd[8*p +: 8]  = fmem[p][fhead[p][4:0]];
        end
    end
    assign bus.req_empty_n = ne;
    assign bus.req_data_i  = hd;

    always @(posedge wb_clk) begin
        for (int p = 0; p < 4; p++) begin
            if (flush) fhead[p] <= ftail[p];
            else if (bus.req_rd_o[p]) fhead[p] <= fhead[p] + 8'd1;
        end
    end

    // Monitor
    int         cyc = 0;
    int         n_tx = 0;
    logic [7:0] log_b [32];
    logic [1:0] log_g [32];
    int         log_c [32];
    int         rd_cnt [4] = '{0, 0, 0, 0};
    int         to_cnt = 0;
    int         to_cyc = 0;
    int         viol_rd = 0;
    int         viol_grant = 0;
    logic       prev_busy = 1'b0;
    logic [1:0] prev_grant = 2'd0;

    always @(posedge wb_clk) begin
        cyc <= cyc + 1;
        if (!wb_rst) begin
            if (bus.tx_valid_o && bus.tx_ready_i) begin
                log_b[n_tx[4:0]] <= bus.tx_data_o;
                log_g[n_tx[4:0]] <= bus.grant_o;
                log_c[n_tx[4:0]] <= cyc;
                n_tx             <= n_tx + 1;
            end
            for (int p = 0; p < 4; p++) begin
                if (bus.req_rd_o[p]) rd_cnt[p] <= rd_cnt[p] + 1;
            end
            if (bus.timeout_o) begin
                to_cnt <= to_cnt + 1;
                to_cyc <= cyc;
            end
            if (!$onehot0(bus.req_rd_o)) viol_rd <= viol_rd + 1;
            if (bus.busy_o && prev_busy && bus.grant_o != prev_grant) viol_grant <= viol_grant + 1;
        end
        prev_busy  <= bus.busy_o;
        prev_grant <= bus.grant_o;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int p, input logic [7:0] b);
        fmem[p][ftail[p][4:0]] = b;
        ftail[p] = ftail[p] + 8'd1;
    endtask

    task automatic wait_ntx(input int target, input int budget);
        int k = 0;
        while (n_tx < target && k < budget) begin
            @(negedge wb_clk);
            k++;
        end
        chk($sformatf("wait_ntx_%0d", target), 32'(n_tx >= target), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.busy_o && k < budget) begin
            @(negedge wb_clk);
            k++;
        end
        chk("wait_idle", 32'(bus.busy_o), 32'd0);
    endtask

    logic [7:0] exp_b [24];
    logic [1:0] exp_g [24];
    int         rdc;
    int         k;

    initial begin
        exp_b = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h3C, 8'h64, 8'h91, 8'h40, 8'h7F, 8'hF8,
                  8'hF8, 8'hC5, 8'h10, 8'h22, 8'hF0, 8'h7E, 8'hF8, 8'h01, 8'hF7, 8'hF8,
                  8'hF1, 8'h20, 8'h90, 8'hFE};
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2,
                  2'd1, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1,
                  2'd3, 2'd3, 2'd1, 2'd0};
        for (int p = 0; p < 4; p++) ftail[p] = 8'd0;
        wb_rst         = 1'b1;
        flush          = 1'b1;
        bus.tx_ready_i = 1'b1;
        repeat (3) @(negedge wb_clk);

        chk("rst_tx_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data_o),  32'd0);
        chk("rst_rd",       32'(bus.req_rd_o),   32'd0);
        chk("rst_grant",    32'(bus.grant_o),    32'd0);
        chk("rst_busy",     32'(bus.busy_o),     32'd0);
        chk("rst_timeout",  32'(bus.timeout_o),  32'd0);
        wb_rst = 1'b0;
        flush  = 1'b0;

        // Note-on from port 2: latency and back-to-back spacing
        push(2, 8'h90); push(2, 8'h3C); push(2, 8'h64);
        @(negedge wb_clk);
        chk("lat_load_rd",    32'(bus.req_rd_o),   32'h4);
        chk("lat_load_busy",  32'(bus.busy_o),     32'd1);
        chk("lat_load_valid", 32'(bus.tx_valid_o), 32'd0);
        @(negedge wb_clk);
        chk("lat_send_valid", 32'(bus.tx_valid_o), 32'd1);
        chk("lat_send_data",  32'(bus.tx_data_o),  32'h90);
        chk("lat_send_grant", 32'(bus.grant_o),    32'd2);
        wait_ntx(3, 40);
        wait_idle(20);
        chk("t1_rd_cnt2", 32'(rd_cnt[2]), 32'd3);
        chk("t1_gap01", 32'(log_c[1] - log_c[0]), 32'd3);
        chk("t1_gap12", 32'(log_c[2] - log_c[1]), 32'd3);

        // Two simultaneous note-ons, ptr at 3 so port 0 first
        push(0, 8'h90); push(0, 8'h3C); push(0, 8'h64);
        push(1, 8'h91); push(1, 8'h40); push(1, 8'h7F);
        wait_ntx(9, 80);
        wait_idle(20);

        // Real-time on ports 1 and 2 with ptr at 2
        push(1, 8'hF8); push(2, 8'hF8);
        wait_ntx(11, 40);
        wait_idle(20);

        // Program change then a later running-status byte
        push(0, 8'hC5); push(0, 8'h10);
        wait_ntx(13, 40);
        wait_idle(20);
        push(0, 8'h22);
        wait_ntx(14, 40);
        wait_idle(20);

        // SysEx with embedded clock; port 1 arrives mid-message
        push(3, 8'hF0); push(3, 8'h7E); push(3, 8'hF8); push(3, 8'h01); push(3, 8'hF7);
        @(negedge wb_clk);
        chk("t4_grant3", 32'(bus.grant_o), 32'd3);
        push(1, 8'hF8);
        wait_ntx(20, 100);
        wait_idle(20);
        push(3, 8'hF1); push(3, 8'h20);
        wait_ntx(22, 40);
        wait_idle(20);
        chk("t4_no_timeout", 32'(to_cnt), 32'd0);

        // Port 1 stalls mid-message; port 0 follows the timeout
        push(1, 8'h90);
        @(negedge wb_clk);
        chk("t5_grant1", 32'(bus.grant_o), 32'd1);
        push(0, 8'hFE);
        wait_ntx(23, 20);
        k = 0;
        while (to_cnt < 1 && k < 30) begin
            @(negedge wb_clk);
            k++;
        end
        chk("t5_to_cnt", 32'(to_cnt), 32'd1);
        chk("t5_to_delay", 32'(to_cyc - log_c[22]), 32'd8);
        wait_ntx(24, 40);
        wait_idle(20);
        // Timeout dropped port 1's running status, so this is stray
        rdc = rd_cnt[1];
        push(1, 8'h40);
        repeat (6) @(negedge wb_clk);
        chk("t5_stray_ntx", 32'(n_tx), 32'd24);
        chk("t5_stray_pop", 32'(rd_cnt[1]), 32'(rdc + 1));

        // Reset while a byte is held in SEND
        bus.tx_ready_i = 1'b0;
        push(2, 8'h92); push(2, 8'h10); push(2, 8'h20);
        k = 0;
        while (!bus.tx_valid_o && k < 10) begin
            @(negedge wb_clk);
            k++;
        end
        chk("t6_send_data", 32'(bus.tx_data_o), 32'h92);
        wb_rst = 1'b1;
        flush  = 1'b1;
        @(negedge wb_clk);
        chk("t6_rst_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("t6_rst_busy",  32'(bus.busy_o),     32'd0);
        chk("t6_rst_grant", 32'(bus.grant_o),    32'd0);
        wb_rst         = 1'b0;
        flush          = 1'b0;
        bus.tx_ready_i = 1'b1;

        // Stray data byte after reset: popped, never transmitted
        push(0, 8'h40);
        @(negedge wb_clk);
        chk("t7_stray_rd", 32'(bus.req_rd_o), 32'h1);
        repeat (5) @(negedge wb_clk);
        chk("t7_stray_ntx",   32'(n_tx),              32'd24);
        chk("t7_stray_busy",  32'(bus.busy_o),        32'd0);
        chk("t7_stray_empty", 32'(bus.req_empty_n[0]), 32'd0);

        for (int i = 0; i < 24; i++) begin
            chk($sformatf("log_byte_%0d", i),  32'(log_b[i]), 32'(exp_b[i]));
            chk($sformatf("log_grant_%0d", i), 32'(log_g[i]), 32'(exp_g[i]));
        end
        chk("viol_rd",    32'(viol_rd),    32'd0);
        chk("viol_grant", 32'(viol_grant), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_merge_arb.md
# midi_merge_arb

Message-aware round-robin arbiter that merges up to four MIDI receive FIFOs onto one byte-wide transmit stream. It sits between the per-input receive FIFOs and the shared MIDI transmitter. A grant is held for a whole MIDI message, including running status and SysEx, so bytes from different inputs never interleave mid-message. A timeout releases a stalled grant.

## Interface
Parameters:
- TIMEOUT, 16'd3125: idle cycles allowed in WAIT before a mid-message grant is abandoned (1 ms at 3.125 MHz).

Ports:
- wb_clk_i  in  1  system clock; only clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_empty_n  in  4  per-port FIFO not-empty.
- req_data_i  in  32  per-port FIFO head byte; port p on bits [8p+7:8p].
- req_rd_o  out  4  per-port pop, one-cycle pulse.
- tx_data_o  out  8  byte to transmitter.
- tx_valid_o  out  1  tx_data_o valid.
- tx_ready_i  in  1  transmitter accepts the byte when tx_valid_o && tx_ready_i.
- grant_o  out  2  currently or last granted port.
- busy_o  out  1  grant held (state is not IDLE).
- timeout_o  out  1  one-cycle pulse when a grant is abandoned on timeout.

## Operation
- FIFO contract: the head byte is valid whenever empty_n=1. After a req_rd_o pulse, the new head and empty_n are valid from the next cycle.
- States: IDLE, LOAD, SEND, WAIT.
- IDLE:
  - Scan ports starting at ptr, wrapping 3→0.
  - The first port with empty_n=1 becomes grant_o. Set first=1 and go to LOAD.
  - If no port has empty_n=1, stay in IDLE.
- LOAD:
  - Register the head byte b into tx_data_o and pulse req_rd_o[grant] for exactly one cycle.
  - Classify b:
    - 0x80–0xEF: rem = 2 for high nibble 8/9/A/B/E, rem = 1 for C/D. Store rs_len[grant] = rem and mark it valid.
    - 0xF0: set sysex=1 and clear rs valid.
    - 0xF1, 0xF3: rem = 1. Clear rs valid.
    - 0xF2: rem = 2. Clear rs valid.
    - 0xF4–0xF7: rem = 0. Clear rs valid, clear sysex.
    - 0xF8–0xFF (real-time): forwarded as-is. rem, sysex and rs are unchanged. If first=1, it is a one-byte message.
    - Data byte with first=1 and rs valid (running status): rem = rs_len − 1.
    - Data byte with first=1 and rs invalid (stray byte): popped but not sent. tx_valid_o stays 0, ptr = grant+1, go to IDLE.
    - Data byte with first=0: rem = rem − 1 unless sysex=1.
  - Go to SEND, except for a stray byte.
- SEND:
  - Hold tx_valid_o=1 and keep tx_data_o stable until tx_ready_i=1.
  - On the handshake, clear first.
  - Message is complete when sysex=0 and rem=0: ptr = grant+1, go to IDLE.
  - Otherwise go to WAIT.
- WAIT:
  - If req_empty_n[grant]=1: clear the timeout counter and go to LOAD.
  - Else increment the counter. When it reaches TIMEOUT: pulse timeout_o, clear sysex and rs valid[grant], ptr = grant+1, go to IDLE.
- Only the granted port is ever popped. Other ports wait regardless of their fill level.

## Timing
- Reset values:
  - Outputs: tx_valid_o=0, tx_data_o=0, req_rd_o=0, grant_o=0, busy_o=0, timeout_o=0.
  - Internal: ptr=0, all rs valid=0, sysex=0, counter=0, state=IDLE.
- Reset mid-message:
  - The next cycle is in IDLE with the reset values above.
  - A byte already popped but not yet accepted is lost.
- Latency, IDLE with a pending port:
  - Cycle 0: grant decided.
  - Cycle 1: LOAD, pop.
  - Cycle 2: tx_valid_o=1.
- Back-to-back bytes with tx_ready_i=1 and data present: 3 cycles per byte (SEND → WAIT → LOAD).
- busy_o=1 in LOAD, SEND and WAIT.
- grant_o changes only in IDLE.
- req_rd_o pulses exactly once per byte, only in LOAD.
- Timeout counter: 16 bits, saturating. It is reset on entry to WAIT from SEND and on leaving WAIT.
- Simultaneous requests: round-robin from ptr; a port is not re-granted while others are pending.

## Test plan
- Reset, then port 2 holds 0x90 0x3C 0x64 with tx_ready_i=1:
  - tx emits 0x90, 0x3C, 0x64.
  - req_rd_o[2] pulses 3 times.
  - ptr ends at 3 and busy_o returns to 0.
- Ports 0 and 1 each hold a 3-byte note-on:
  - Port 0's message goes out in full, then port 1's.
  - No interleaving.
  - grant_o sequence is 0, 1.
- Port 0 holds 0xC5 0x10, then later 0x22 (running status):
  - Output is 0xC5, 0x10, then 0x22 as a separate one-byte message.
- Port 3 holds 0xF0 0x7E 0x01 0xF7, and 0xF8 is inserted after 0x7E:
  - All 5 bytes go out on port 3 before any other grant.
  - After 0xF7, sysex is cleared.
- Port 1 sends 0x90 then goes empty, with TIMEOUT=8:
  - timeout_o pulses 8 WAIT cycles after the 0x90 handshake.
  - Port 0's pending byte is granted next.
- Port 0 holds a stray 0x40 after reset:
  - The byte is popped and tx_valid_o stays 0.
- wb_rst_i is asserted mid-SEND:
  - Next cycle: tx_valid_o=0 and busy_o=0.
